vga_text: RTL and testbench
===========================

VGA_TEXT -- requirements
Module: vga_text

Interface
REQ-001 Parameter COLS, default 80: text columns; COLS*8 <= 640.
REQ-002 Parameter ROWS, default 30: text rows; ROWS*CHAR_H <= 480.
REQ-003 Parameter CHAR_H, default 16: glyph height in lines, power of two, 8 or 16.
REQ-004 Parameter ATTR_EN, default 1: 1 = attribute byte used; 0 = fixed fg 7 (light grey) on bg 0 (black).
REQ-005 clock  in  1  25 MHz pixel clock; only clock of the block.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 char_addr  out  clog2(COLS*ROWS)  text RAM cell address.
REQ-008 char_data  in  16  [7:0] code, [11:8] fg, [14:12] bg, [15] blink; valid 1 clock after char_addr.
REQ-009 font_addr  out  8+clog2(CHAR_H)  {code, glyph line}.
REQ-010 font_data  in  8  glyph row, bit 7 = leftmost pixel; valid 1 clock after font_addr.
REQ-011 cursor_x / cursor_y  in  clog2(COLS) / clog2(ROWS)  cursor cell.
REQ-012 cursor_en  in  1  cursor display enable.
REQ-013 r, g, b  out  4 each  colour; hs, vs  out  1 each  syncs, active low.
REQ-014 frame  out  1  one-clock pulse at the start of vertical blank, for the CPU interrupt.

Function
REQ-015 Timing: H total 800 = 640 visible + 16 front + 96 sync + 48 back; V total 525 = 480 visible + 10 front + 2 sync + 33 back.
REQ-016 Counters x (0..799) and y (0..524); x wraps 799->0 and increments y; y wraps 524->0.
REQ-017 hs is low for x in 656..751; vs is low for y in 490..491.
REQ-018 char_addr = (y/CHAR_H)*COLS + x/8, combinational from the registered counters, held within an 8-pixel cell.
REQ-019 font_addr = {char_data[7:0], y mod CHAR_H}, driven on the clock after char_addr.
REQ-020 Pixel bit = font_data[7 - (x mod 8)], using x delayed by 2 clocks.
REQ-021 r/g/b/hs/vs are registered with a fixed 3-clock latency from counter state; syncs are delayed by the same 3 clocks, so pixel alignment is exact.
REQ-022 Colour index = fg if the pixel bit is 1, else bg; 4-bit index maps through the 16-entry CGA palette to 12-bit RGB.
REQ-023 When ATTR_EN = 1 and blink = 1, fg is replaced by bg while blink_phase = 0.
REQ-024 blink_phase toggles every 16 frames; the frame counter is 5 bits and wraps.
REQ-025 Cursor cell: when cursor_en = 1 and blink_phase = 1, glyph lines CHAR_H-2 and CHAR_H-1 of cell (cursor_x, cursor_y) show fg.
REQ-026 Outside 640x480, or y >= ROWS*CHAR_H, or x >= COLS*8: r = g = b = 0.
REQ-027 frame pulses high for exactly one clock when x = 0 and y = 480, in counter time (undelayed).
REQ-028 Out-of-range cursor_x/cursor_y show no cursor; no wrap and no error.
REQ-029 A change of cursor or text RAM takes effect at the next fetch; there is no frame buffering.

Reset
REQ-030 While reset_n = 0 at a rising clock edge: x = y = 0; frame counter = 0; blink_phase = 0; pipeline registers = 0; r = g = b = 0; hs = vs = 1; frame = 0.
REQ-031 A reset asserted mid-line or mid-frame takes effect on the next edge; the first post-reset pixel is (0,0).

Structure
REQ-032 The shared package vga_pkg holds the H/V timing constants and the 16 x 12-bit CGA palette.
REQ-033 Sub-module vga_timing contains the x/y counters, raw syncs, the visible flag and the frame pulse; vga_text contains the fetch pipeline, attributes, cursor and blink.

Verification
REQ-034 Reset, then free-run 800*525 clocks -> hs low 96 clocks per line starting at x = 656+3; vs low for 2 lines; exactly 1 frame pulse.
REQ-035 Cell (0,0) = 16'h1E41, font 'A' line 0 = 8'h18 -> pixels 3..4 = palette[14] (yellow), others = palette[1] (blue), on r/g/b 3 clocks after counter x.
REQ-036 Cell (79,29) = 16'h0720, blank glyph -> pixels 632..639 on lines 464..479 = black; x = 640 -> 0 regardless of data.
REQ-037 cursor_en = 1, cursor at (5,2), glyph blank, attribute 0x0F -> lines 46..47, x 40..47 white during blink_phase = 1 frames and black during blink_phase = 0.
REQ-038 Attribute 0x8F (blink set) -> fg hidden for 16 frames, shown for the next 16 frames.
REQ-039 reset_n low for 1 clock at x = 300, y = 200 -> the next clock x = y = 0, hs = vs = 1, rgb = 0; timing then matches REQ-034.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text-mode display.
//   - 640x480@60 horizontal/vertical timing constants (pixel clock 25 MHz)
//   - attribute byte layout (char_data[15:8])
//   - 16-entry CGA palette, 12-bit {r,g,b}
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  // Attribute byte: [7] blink, [6:4] background, [3:0] foreground.
  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  // Used when the attribute byte is ignored: light grey on black.
  localparam attr_t FIXED_ATTR = '{blink: 1'b0, bg: 3'd0, fg: 4'd7};

  localparam logic [11:0] CGA_PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage

// File: rtl/vga_text_if.sv
// Memory-side bus of the text display: text RAM and font ROM lookups.
//   char_addr  text cell address (master out)
//   char_data  {blink, bg, fg, code}, valid one clock after char_addr (slave out)
//   font_addr  {code, glyph line} (master out)
//   font_data  glyph row, bit 7 leftmost, valid one clock after font_addr (slave out)
interface vga_text_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CHAR_H = 16
);
  localparam int AW = $clog2(COLS * ROWS);
  localparam int FW = 8 + $clog2(CHAR_H);

  logic [AW-1:0] char_addr;
  logic [15:0]   char_data;
  logic [FW-1:0] font_addr;
  logic [7:0]    font_data;

  modport master (output char_addr, output font_addr,
                  input  char_data, input  font_data);
  modport slave  (input  char_addr, input  font_addr,
                  output char_data, output font_data);
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator.
//   clock, reset_n  pixel clock, synchronous active-low reset
//   x, y            registered pixel/line counters
//   hs_raw, vs_raw  undelayed syncs (active low)
//   visible         counters inside the active area
//   frame           one-clock pulse at (0, first blank line)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SY  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SY  = V_SYNC,
  parameter int V_BP  = V_BACK,
  localparam int H_TOTAL = H_VIS + H_FP + H_SY + H_BP,
  localparam int V_TOTAL = V_VIS + V_FP + V_SY + V_BP,
  localparam int XW = $clog2(H_TOTAL),
  localparam int YW = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          visible,
  output logic          frame
);

  localparam int HS_FIRST = H_VIS + H_FP;
  localparam int HS_LAST  = H_VIS + H_FP + H_SY - 1;
  localparam int VS_FIRST = V_VIS + V_FP;
  localparam int VS_LAST  = V_VIS + V_FP + V_SY - 1;

  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
    end
  end

  always_comb begin
    x_next = x_reg + 1'b1;
    y_next = y_reg;
    if (x_reg == XW'(H_TOTAL - 1)) begin
      x_next = '0;
      if (y_reg == YW'(V_TOTAL - 1)) y_next = '0;
      else                           y_next = y_reg + 1'b1;
    end
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign hs_raw  = !((x_reg >= XW'(HS_FIRST)) && (x_reg <= XW'(HS_LAST)));
  assign vs_raw  = !((y_reg >= YW'(VS_FIRST)) && (y_reg <= YW'(VS_LAST)));
  assign visible = (x_reg < XW'(H_VIS)) && (y_reg < YW'(V_VIS));
  assign frame   = (x_reg == '0) && (y_reg == YW'(V_VIS));

endmodule

// File: rtl/vga_text.sv
// Character-cell VGA display: fetch pipeline, attributes, cursor and blink.
//   clock, reset_n        pixel clock, synchronous active-low reset
//   mem                   text RAM / font ROM bus (master side)
//   cursor_x/_y/_en       cursor cell and enable
//   r, g, b               4-bit colour, registered
//   hs, vs                syncs (active low), aligned with r/g/b
//   frame                 one-clock pulse at start of vertical blank
// Pipeline: stage 0 = counters / char_addr, stage 1 = char_data / font_addr,
// stage 2 = font_data / colour select, stage 3 = output registers.
// Timing parameters default to 640x480@60 and may be overridden for other modes.
module vga_text
  import vga_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int CHAR_H  = 16,
  parameter int ATTR_EN = 1,
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FP    = H_FRONT,
  parameter int H_SY    = H_SYNC,
  parameter int H_BP    = H_BACK,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FP    = V_FRONT,
  parameter int V_SY    = V_SYNC,
  parameter int V_BP    = V_BACK,
  localparam int CXW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int CYW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic           clock,
  input  logic           reset_n,
  vga_text_if.master     mem,
  input  logic [CXW-1:0] cursor_x,
  input  logic [CYW-1:0] cursor_y,
  input  logic           cursor_en,
  output logic [3:0]     r,
  output logic [3:0]     g,
  output logic [3:0]     b,
  output logic           hs,
  output logic           vs,
  output logic           frame
);

  localparam int XW = $clog2(H_VIS + H_FP + H_SY + H_BP);
  localparam int YW = $clog2(V_VIS + V_FP + V_SY + V_BP);
  localparam int AW = $clog2(COLS * ROWS);
  localparam int LW = $clog2(CHAR_H);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          hs_raw, vs_raw, visible;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SY(H_SY), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SY(V_SY), .V_BP(V_BP)
  ) u_timing (
    .clock   (clock),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw),
    .visible (visible),
    .frame   (frame)
  );

  // Stage 0: cell lookup straight from the counters.
  int          col_s0, row_s0;
  logic [LW-1:0] line_s0;
  logic        text_s0, cursor_s0;

  assign col_s0  = int'(x) / 8;
  assign row_s0  = int'(y) / CHAR_H;
  assign line_s0 = y[LW-1:0];
  assign text_s0 = visible && (col_s0 < COLS) && (row_s0 < ROWS);
  // An out-of-range cursor never matches because text_s0 bounds col/row.
  assign cursor_s0 = cursor_en && text_s0
                  && (col_s0 == int'(cursor_x)) && (row_s0 == int'(cursor_y))
                  && (line_s0 >= LW'(CHAR_H - 2));
  assign mem.char_addr = AW'(row_s0 * COLS + col_s0);

  // Pipeline registers.
  logic [2:0]    x_lo_d1, x_lo_d2;
  logic [LW-1:0] line_d1;
  logic          text_d1, text_d2;
  logic          cursor_d1, cursor_d2;
  attr_t         attr_d2;
  logic [2:0]    hs_pipe, vs_pipe;
  logic [4:0]    frame_cnt_reg;
  logic [11:0]   rgb_reg, rgb_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_lo_d1       <= '0;
      x_lo_d2       <= '0;
      line_d1       <= '0;
      text_d1       <= 1'b0;
      text_d2       <= 1'b0;
      cursor_d1     <= 1'b0;
      cursor_d2     <= 1'b0;
      attr_d2       <= '0;
      hs_pipe       <= '1;
      vs_pipe       <= '1;
      frame_cnt_reg <= '0;
      rgb_reg       <= '0;
    end else begin
      x_lo_d1   <= x[2:0];
      line_d1   <= line_s0;
      text_d1   <= text_s0;
      cursor_d1 <= cursor_s0;
      x_lo_d2   <= x_lo_d1;
      text_d2   <= text_d1;
      cursor_d2 <= cursor_d1;
      attr_d2   <= attr_t'(mem.char_data[15:8]);
      // Syncs travel the same three stages as the pixel data.
      hs_pipe   <= {hs_pipe[1:0], hs_raw};
      vs_pipe   <= {vs_pipe[1:0], vs_raw};
      rgb_reg   <= rgb_next;
      if (frame) frame_cnt_reg <= frame_cnt_reg + 5'd1;
    end
  end

  // Stage 1: glyph line lookup from the freshly returned character code.
  assign mem.font_addr = {mem.char_data[7:0], line_d1};

  // Stage 2: colour selection.
  attr_t attr_s2;
  generate
    if (ATTR_EN != 0) begin : g_attr
      assign attr_s2 = attr_d2;
    end else begin : g_fixed_attr
      assign attr_s2 = FIXED_ATTR;
    end
  endgenerate

  logic       blink_phase, pixel_bit, pixel_on;
  logic [3:0] fg_idx, bg_idx;

  always_comb begin
    blink_phase = frame_cnt_reg[4];
    pixel_bit   = mem.font_data[3'd7 - x_lo_d2];
    bg_idx      = {1'b0, attr_s2.bg};
    // Blinking text shows background colour during the off half-period.
    fg_idx      = (attr_s2.blink && !blink_phase) ? bg_idx : attr_s2.fg;
    pixel_on    = pixel_bit || (cursor_d2 && blink_phase);
    rgb_next    = 12'h000;
    if (text_d2) rgb_next = CGA_PALETTE[pixel_on ? fg_idx : bg_idx];
  end

  assign r  = rgb_reg[11:8];
  assign g  = rgb_reg[7:4];
  assign b  = rgb_reg[3:0];
  assign hs = hs_pipe[2];
  assign vs = vs_pipe[2];

endmodule

// File: tb/tb_vga_text.sv
module tb_vga_text;

  localparam int COLS = 6, ROWS = 3, CHAR_H = 8;
  localparam int H_VIS = 64, H_FP = 4, H_SY = 8, H_BP = 4;
  localparam int V_VIS = 32, V_FP = 2, V_SY = 2, V_BP = 4;
  localparam int HT = H_VIS + H_FP + H_SY + H_BP;
  localparam int VT = V_VIS + V_FP + V_SY + V_BP;
  localparam int FRAME_CLKS = HT * VT;
  localparam int AW = $clog2(COLS * ROWS);
  localparam int FW = 8 + $clog2(CHAR_H);

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] cursor_x;
  logic [1:0] cursor_y;
  logic       cursor_en;
  logic [3:0] r, g, b;
  logic       hs, vs, frame;

  always #20 clock = ~clock;

  vga_text_if #(.COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H)) mem_if ();

  vga_text #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .ATTR_EN(1),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SY(H_SY), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SY(V_SY), .V_BP(V_BP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem       (mem_if),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .cursor_en (cursor_en),
    .r         (r),
    .g         (g),
    .b         (b),
    .hs        (hs),
    .vs        (vs),
    .frame     (frame)
  );

  // Text RAM and font ROM with registered reads.
  logic [15:0] text_ram [2**AW];
  logic [7:0]  font_rom [2**FW];
  always @(posedge clock) begin
    mem_if.char_data <= text_ram[mem_if.char_addr];
    mem_if.font_data <= font_rom[mem_if.font_addr];
  end

  logic [11:0] pal [16];
  int k;
  int n_checks = 0;
  int n_fail = 0;
  int hs_lo, vs_lo, pulses;

  // Expected {frame, hs, vs, rgb} at cycle k after reset release.
  function automatic logic [14:0] exp_out(input int kk);
    int p, f, w, x, y;
    logic [15:0] cd;
    logic [7:0]  gl;
    logic [3:0]  fg, bg;
    logic [11:0] rgb;
    bit frm, hsx, vsx, ph, cur, on;
    frm = ((kk % FRAME_CLKS) == V_VIS * HT);
    p = kk - 3;
    if (p < 0) return {frm, 1'b1, 1'b1, 12'h000};
    f = p / FRAME_CLKS;
    w = p % FRAME_CLKS;
    x = w % HT;
    y = w / HT;
    hsx = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SY);
    vsx = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SY);
    rgb = 12'h000;
    if (x < COLS * 8 && y < ROWS * CHAR_H) begin
      cd  = text_ram[(y / CHAR_H) * COLS + x / 8];
      gl  = font_rom[cd[7:0] * CHAR_H + y % CHAR_H];
      ph  = ((f / 16) % 2) == 1;
      fg  = cd[11:8];
      bg  = {1'b0, cd[14:12]};
      if (cd[15] && !ph) fg = bg;
      cur = cursor_en && ph && int'(cursor_x) == x / 8 && int'(cursor_y) == y / CHAR_H
            && (y % CHAR_H) >= CHAR_H - 2;
      on  = gl[7 - x % 8] || cur;
      rgb = pal[on ? fg : bg];
    end
    return {frm, hsx, vsx, rgb};
  endfunction

  task automatic check_cycle();
    logic [14:0] got, want;
    logic [11:0] rgb;
    int p, f, x, y;
    got  = {frame, hs, vs, r, g, b};
    want = exp_out(k);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL pix k=%0d got=%h exp=%h", k, got, want);
    end
    p = k - 3;
    if (p >= 0) begin
      f = p / FRAME_CLKS;
      x = (p % FRAME_CLKS) % HT;
      y = (p % FRAME_CLKS) / HT;
      rgb = {r, g, b};
      if (y == 0 && x < 8) begin
        n_checks++;
        assert (rgb === ((x == 3 || x == 4) ? 12'hFF5 : 12'h00A)) else begin
          n_fail++;
          $error("FAIL cell00 x=%0d got=%h", x, rgb);
        end
      end
      if (f >= 14 && f <= 16 && (y == 14 || y == 15) && x >= 16 && x < 24) begin
        n_checks++;
        assert (rgb === ((f >= 16) ? 12'hFFF : 12'h000)) else begin
          n_fail++;
          $error("FAIL cursor f=%0d x=%0d y=%0d got=%h", f, x, y, rgb);
        end
      end
      if (f < 16 && y >= 8 && y < 16 && x >= 24 && x < 32) begin
        n_checks++;
        assert (rgb === 12'h000) else begin
          n_fail++;
          $error("FAIL blink_hidden f=%0d x=%0d y=%0d got=%h exp=000", f, x, y, rgb);
        end
      end
      if (x >= COLS * 8 || (y >= 16 && y < 24 && x >= 40 && x < 48)) begin
        n_checks++;
        assert (rgb === 12'h000) else begin
          n_fail++;
          $error("FAIL blank x=%0d y=%0d got=%h exp=000", x, y, rgb);
        end
      end
    end
  endtask

  task automatic check_addr0();
    n_checks++;
    assert (mem_if.char_addr === AW'(0)) else begin
      n_fail++;
      $error("FAIL rst_addr got=%0d exp=0", mem_if.char_addr);
    end
  endtask

  task automatic step();
    @(posedge clock);
    k++;
    @(negedge clock);
    check_cycle();
    if (!hs) hs_lo++;
    if (!vs) vs_lo++;
    if (frame) pulses++;
    if (k % FRAME_CLKS == 2) begin
      if (k >= FRAME_CLKS) begin
        n_checks++;
        assert (hs_lo === VT * H_SY) else begin
          n_fail++; $error("FAIL hs_count got=%0d exp=%0d", hs_lo, VT * H_SY);
        end
        n_checks++;
        assert (vs_lo === V_SY * HT) else begin
          n_fail++; $error("FAIL vs_count got=%0d exp=%0d", vs_lo, V_SY * HT);
        end
        n_checks++;
        assert (pulses === 1) else begin
          n_fail++; $error("FAIL frame_count got=%0d exp=1", pulses);
        end
      end
      hs_lo = 0; vs_lo = 0; pulses = 0;
    end
  endtask

  // Contents change only at the frame pulse, well inside vertical blank.
  task automatic frame_update(input int fr);
    int idx;
    if (fr <= 12) begin
      for (int i = 0; i < 3; i++) begin
        idx = $urandom_range(0, COLS * ROWS - 1);
        if (idx != 0 && idx != 8 && idx != 9 && idx != 17) text_ram[idx] = 16'($urandom);
      end
      cursor_x  = 3'($urandom_range(0, 7));
      cursor_y  = 2'($urandom_range(0, 3));
      cursor_en = 1'($urandom_range(0, 1));
    end else if (fr == 13) begin
      cursor_x = 3'd2; cursor_y = 2'd1; cursor_en = 1'b1;
    end else if (fr == 16) begin
      cursor_x = 3'(6 + $urandom_range(0, 1));
      cursor_y = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic run_to(input int kend);
    while (k < kend) begin
      step();
      if (k % FRAME_CLKS == V_VIS * HT) frame_update(k / FRAME_CLKS);
    end
  endtask

  initial begin
    pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 2**AW; i++) text_ram[i] = 16'($urandom);
    for (int i = 0; i < 2**FW; i++) font_rom[i] = 8'($urandom);
    for (int l = 0; l < CHAR_H; l++) font_rom[8'h20 * CHAR_H + l] = 8'h00;
    font_rom[8'h41 * CHAR_H] = 8'h18;
    text_ram[0]  = 16'h1E41;  // yellow 'A' on blue
    text_ram[8]  = 16'h0F20;  // cursor cell (2,1): white on black, blank
    text_ram[9]  = 16'h8F41;  // blinking white 'A' on black
    text_ram[17] = 16'h0720;  // last cell, blank
    cursor_x = 3'd0; cursor_y = 2'd0; cursor_en = 1'b0;
    hs_lo = 0; vs_lo = 0; pulses = 0;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;
    check_cycle();
    check_addr0();

    run_to(18 * FRAME_CLKS + 20 * HT + 30);

    // One-clock reset in the middle of a line.
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;
    hs_lo = 0; vs_lo = 0; pulses = 0;
    check_cycle();
    check_addr0();

    run_to(FRAME_CLKS + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
